dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory (256 x 32) between two requesters: the pipeline MEM stage and an external DMA/loader port.
- The pipeline has priority by default. A starvation counter guarantees the DMA port a slot by stalling the pipeline for one cycle.
- Sits between the EX/MEM register outputs and the dataMemory instance. Its stall output feeds the hazard/hold network.

Parameters:
- ADDR_W, 8, memory word-address width.
- DATA_W, 32, data width.
- STARVE_LIMIT, 4, number of consecutive denied DMA cycles after which the DMA port is forced through (legal range 1..255).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-low reset.
- pipe_rden  in  1  MEM-stage read request.
- pipe_wren  in  1  MEM-stage write request.
- pipe_addr  in  ADDR_W  MEM-stage address.
- pipe_wdata  in  DATA_W  MEM-stage store data.
- pipe_rdata  out  DATA_W  load data to MEM/WB; equals mem_q, combinational.
- pipe_hold  out  1  pipeline stall request, combinational.
- dma_req  in  1  DMA access request; held until granted.
- dma_we  in  1  1 = write, 0 = read; valid with dma_req.
- dma_addr  in  ADDR_W  DMA address.
- dma_wdata  in  DATA_W  DMA write data.
- dma_gnt  out  1  DMA access performed this cycle, combinational.
- dma_rdata  out  DATA_W  registered DMA read data.
- dma_rvalid  out  1  one-cycle pulse; dma_rdata is valid.
- mem_address  out  ADDR_W  to memory.
- mem_data  out  DATA_W  to memory.
- mem_rden  out  1  to memory.
- mem_wren  out  1  to memory.
- mem_q  in  DATA_W  memory read data. Memory is clocked on the falling edge, so mem_q is valid before the rising edge that ends the request cycle.

Behaviour:
- Definitions:
  - pipe_acc = pipe_rden | pipe_wren.
  - force = (wait_cnt == STARVE_LIMIT).
- wait_cnt: register of width clog2(STARVE_LIMIT+1).
  - Clears on a cycle with dma_gnt=1.
  - Clears when dma_req=0.
  - Increments when dma_req=1 and dma_gnt=0; saturates at STARVE_LIMIT.
- Ownership each cycle, combinational from current inputs and state:
  - dma_gnt = dma_req & (force | ~pipe_acc).
  - pipe_hold = dma_req & force & pipe_acc.
  - Owner = DMA when dma_gnt, else pipeline.
- Memory mux:
  - Owner pipeline: mem_address = pipe_addr, mem_data = pipe_wdata, mem_wren = pipe_wren, mem_rden = pipe_rden & ~pipe_wren.
  - Owner DMA: mem_address = dma_addr, mem_data = dma_wdata, mem_wren = dma_we, mem_rden = ~dma_we.
  - Idle (no pipe_acc, no dma_gnt): mem_rden = mem_wren = 0. Address and data are driven from the pipe_* inputs.
  - Write wins when pipe_rden and pipe_wren are both high. The read is suppressed.
- Pipeline contract: while pipe_hold=1, the pipeline must present the same request unchanged on the next cycle.
  - pipe_rdata during a held cycle carries DMA data and must be ignored.
  - A held cycle is followed by a pipeline-owned cycle, because wait_cnt is cleared by the grant.
- DMA read return:
  - On the rising edge ending a cycle with dma_gnt=1 and dma_we=0, dma_rdata <= mem_q and dma_rvalid <= 1. dma_rvalid is otherwise 0 next cycle.
  - Latency: one cycle from grant to rvalid.
  - dma_rdata holds its value until the next DMA read.
- DMA writes: complete in the grant cycle. No response is generated.
- Back-to-back DMA: a new request may be presented in the cycle after dma_gnt. Each granted cycle is one independent access.
- Reset (rst=0, asynchronous, any time including mid-hold): wait_cnt=0, dma_rvalid=0, dma_rdata=0.
  - The combinational outputs follow their equations with wait_cnt=0.
  - A DMA read granted in the cycle reset asserts produces no rvalid.
- Simultaneous events:
  - force while pipeline idle: grant, pipe_hold=0.
  - dma_req dropped while wait_cnt>0: counter clears and no grant is issued (dma_req must not be dropped before grant; the bench checks recovery only).

Test Plan:
- Reset with dma_req=1, pipeline idle -> dma_rvalid=0; after rst release, read dma_addr=8'h10 with memory word 0x0000CAFE -> dma_gnt same cycle, next cycle dma_rvalid=1, dma_rdata=0x0000CAFE.
- Pipeline stores continuously to addr 8'h20 with wdata 0x11111111, DMA read pending, STARVE_LIMIT=4 -> dma_gnt=0 for 4 cycles; 5th cycle dma_gnt=1 and pipe_hold=1, mem_address=DMA address; 6th cycle pipe_hold=0, pipeline store to 8'h20 is written.
- DMA write 0xDEADBEEF to addr 8'h05 with pipeline idle, then pipeline load of 8'h05 -> pipe_rdata=0xDEADBEEF; dma_rvalid stays 0 for the write.
- pipe_rden=pipe_wren=1 -> mem_wren=1, mem_rden=0.
- Assert rst low during a forced-grant cycle -> dma_rvalid=0 and wait_cnt=0; after release, a DMA request against a busy pipeline needs a full 4 denied cycles again.
- Alternating pipeline accesses with DMA requests in idle gaps -> every DMA request granted in the first idle cycle, pipe_hold never asserted.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: pipeline MEM stage vs DMA/loader port.
// Pipeline wins by default; a starvation counter forces DMA through.
module dmem_arbiter #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pipe_rden,
    input  logic              pipe_wren,
    input  logic [ADDR_W-1:0] pipe_addr,
    input  logic [DATA_W-1:0] pipe_wdata,
    output logic [DATA_W-1:0] pipe_rdata,
    output logic              pipe_hold,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_rvalid,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_rden,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] wait_cnt;
    logic             pipe_acc;
    logic             force_grant;

    assign pipe_acc    = pipe_rden | pipe_wren;
    assign force_grant = (wait_cnt == LIMIT);
    assign dma_gnt     = dma_req & (force_grant | ~pipe_acc);
    assign pipe_hold   = dma_req & force_grant & pipe_acc;
    assign pipe_rdata  = mem_q;

    // Route the owning requester onto the memory port; writes beat reads.
    always_comb begin
        mem_address = pipe_addr;
        mem_data    = pipe_wdata;
        mem_wren    = pipe_wren;
        mem_rden    = pipe_rden & ~pipe_wren;
        if (dma_gnt) begin
            mem_address = dma_addr;
            mem_data    = dma_wdata;
            mem_wren    = dma_we;
            mem_rden    = ~dma_we;
        end
    end

    // Count consecutive denied DMA cycles, saturating at the limit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (!dma_req || dma_gnt) begin
            wait_cnt <= '0;
        end else if (!force_grant) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Capture DMA read data one cycle after the grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dma_rvalid <= 1'b0;
            dma_rdata  <= '0;
        end else begin
            dma_rvalid <= dma_gnt & ~dma_we;
            if (dma_gnt && !dma_we) begin
                dma_rdata <= mem_q;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a falling-edge memory
// and a transaction-level reference model.
module tb_dmem_arbiter;

    localparam int S = 4;

    logic        clk;
    logic        rst;
    logic        pipe_rden, pipe_wren;
    logic [7:0]  pipe_addr;
    logic [31:0] pipe_wdata, pipe_rdata;
    logic        pipe_hold;
    logic        dma_req, dma_we;
    logic [7:0]  dma_addr;
    logic [31:0] dma_wdata, dma_rdata;
    logic        dma_gnt, dma_rvalid;
    logic [7:0]  mem_address;
    logic [31:0] mem_data, mem_q;
    logic        mem_rden, mem_wren;

    int checks = 0;
    int errors = 0;

    dmem_arbiter #(.ADDR_W(8), .DATA_W(32), .STARVE_LIMIT(S)) dut (
        .clk(clk), .rst(rst),
        .pipe_rden(pipe_rden), .pipe_wren(pipe_wren),
        .pipe_addr(pipe_addr), .pipe_wdata(pipe_wdata),
        .pipe_rdata(pipe_rdata), .pipe_hold(pipe_hold),
        .dma_req(dma_req), .dma_we(dma_we),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rdata(dma_rdata),
        .dma_rvalid(dma_rvalid),
        .mem_address(mem_address), .mem_data(mem_data),
        .mem_rden(mem_rden), .mem_wren(mem_wren),
        .mem_q(mem_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(int i);
        if (i == 16) return 32'h0000CAFE;
        return (32'(i) * 32'h9E3779B9) ^ 32'h13579BDF;
    endfunction

    // Falling-edge single-port memory
    logic [31:0] mem [256];
    initial begin
        mem_q = '0;
        for (int i = 0; i < 256; i++) mem[i] = init_word(i);
        forever begin
            @(negedge clk);
            if (mem_rden) mem_q = mem[mem_address];
            if (mem_wren) mem[mem_address] = mem_data;
        end
    end

    // Reference model
    logic [31:0] ref_mem [256];
    int          denied;
    logic        m_rvalid;
    logic [31:0] m_rdata;
    logic        last_gnt, last_hold;
    logic        exp_gnt, exp_hold, exp_wren, exp_rden;
    logic [7:0]  exp_addr;
    logic [31:0] exp_data, exp_q;

    task automatic model_reset();
        denied = 0; m_rvalid = 1'b0; m_rdata = '0;
        last_gnt = 1'b0; last_hold = 1'b0;
    endtask

    task automatic model_eval();
        bit pacc, starved;
        pacc = pipe_rden || pipe_wren;
        starved = (denied >= S);
        exp_gnt = dma_req && (starved || !pacc);
        exp_hold = dma_req && starved && pacc;
        if (exp_gnt) begin
            exp_addr = dma_addr; exp_data = dma_wdata;
            exp_wren = dma_we; exp_rden = !dma_we;
        end else begin
            exp_addr = pipe_addr; exp_data = pipe_wdata;
            exp_wren = pipe_wren; exp_rden = pipe_rden && !pipe_wren;
        end
        exp_q = ref_mem[exp_addr];
    endtask

    task automatic model_update();
        if (!rst) begin
            model_reset();
        end else begin
            m_rvalid = exp_gnt && !dma_we;
            if (m_rvalid) m_rdata = ref_mem[dma_addr];
            if (exp_wren) ref_mem[exp_addr] = exp_data;
            if (exp_gnt || !dma_req) denied = 0;
            else if (denied < S) denied = denied + 1;
            last_gnt = exp_gnt; last_hold = exp_hold;
        end
    endtask

    task automatic mid();
        @(negedge clk); #1; model_eval();
    endtask

    task automatic nxt();
        @(posedge clk); model_update(); #1;
    endtask

    task automatic set_pipe(logic r, logic w, logic [7:0] a, logic [31:0] d);
        pipe_rden = r; pipe_wren = w; pipe_addr = a; pipe_wdata = d;
    endtask

    task automatic set_dma(logic q, logic w, logic [7:0] a, logic [31:0] d);
        dma_req = q; dma_we = w; dma_addr = a; dma_wdata = d;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        set_pipe(0, 0, 8'h00, 32'h0);
        set_dma(1, 0, 8'h10, 32'h0);
        mid();
        checks++; if (dma_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got=%0b exp=0", dma_rvalid); end
        checks++; if (dma_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", dma_rdata); end
        checks++; if (dma_gnt !== 1'b1) begin errors++; $display("FAIL reset_gnt got=%0b exp=1", dma_gnt); end
        nxt();
        checks++; if (dma_rvalid !== 1'b0) begin errors++; $display("FAIL reset_read_rvalid got=%0b exp=0", dma_rvalid); end
        rst = 1'b1;
        mid();
        checks++; if (dma_gnt !== 1'b1 || mem_address !== 8'h10 || mem_rden !== 1'b1) begin
            errors++; $display("FAIL first_read gnt=%0b addr=%h rden=%0b exp 1/10/1", dma_gnt, mem_address, mem_rden); end
        nxt();
        set_dma(0, 0, 8'h00, 32'h0);
        mid();
        checks++; if (dma_rvalid !== 1'b1 || dma_rdata !== 32'h0000CAFE) begin
            errors++; $display("FAIL first_rdata rvalid=%0b data=%h exp 1/0000cafe", dma_rvalid, dma_rdata); end
        nxt();
        mid();
        checks++; if (dma_rvalid !== 1'b0 || dma_rdata !== 32'h0000CAFE) begin
            errors++; $display("FAIL rvalid_pulse rvalid=%0b data=%h exp 0/0000cafe", dma_rvalid, dma_rdata); end
        nxt();
    endtask

    task automatic test_starve();
        set_pipe(0, 1, 8'h20, 32'h11111111);
        set_dma(1, 0, 8'h33, 32'h0);
        for (int c = 1; c <= S; c++) begin
            mid();
            checks++; if (dma_gnt !== 1'b0 || pipe_hold !== 1'b0 || mem_address !== 8'h20 || mem_wren !== 1'b1) begin
                errors++; $display("FAIL starve_deny c=%0d gnt=%0b hold=%0b addr=%h wren=%0b", c, dma_gnt, pipe_hold, mem_address, mem_wren); end
            nxt();
        end
        mid();
        checks++; if (dma_gnt !== 1'b1 || pipe_hold !== 1'b1 || mem_address !== 8'h33 || mem_rden !== 1'b1 || mem_wren !== 1'b0) begin
            errors++; $display("FAIL starve_force gnt=%0b hold=%0b addr=%h rden=%0b wren=%0b exp 1/1/33/1/0", dma_gnt, pipe_hold, mem_address, mem_rden, mem_wren); end
        nxt();
        set_dma(0, 0, 8'h00, 32'h0);
        mid();
        checks++; if (pipe_hold !== 1'b0 || mem_wren !== 1'b1 || mem_address !== 8'h20 || mem_data !== 32'h11111111) begin
            errors++; $display("FAIL starve_after hold=%0b wren=%0b addr=%h data=%h", pipe_hold, mem_wren, mem_address, mem_data); end
        checks++; if (dma_rvalid !== 1'b1 || dma_rdata !== m_rdata) begin
            errors++; $display("FAIL starve_rdata rvalid=%0b got=%h exp=%h", dma_rvalid, dma_rdata, m_rdata); end
        nxt();
        set_pipe(1, 0, 8'h20, 32'h0);
        mid();
        checks++; if (pipe_rdata !== 32'h11111111) begin errors++; $display("FAIL starve_store got=%h exp=11111111", pipe_rdata); end
        nxt();
    endtask

    task automatic test_dma_write();
        set_pipe(0, 0, 8'h00, 32'h0);
        set_dma(1, 1, 8'h05, 32'hDEADBEEF);
        mid();
        checks++; if (dma_gnt !== 1'b1 || mem_wren !== 1'b1 || mem_address !== 8'h05 || mem_data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL dma_write gnt=%0b wren=%0b addr=%h data=%h", dma_gnt, mem_wren, mem_address, mem_data); end
        nxt();
        set_dma(0, 0, 8'h00, 32'h0);
        set_pipe(1, 0, 8'h05, 32'h0);
        mid();
        checks++; if (dma_rvalid !== 1'b0) begin errors++; $display("FAIL dma_write_rvalid got=%0b exp=0", dma_rvalid); end
        checks++; if (pipe_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL dma_write_load got=%h exp=deadbeef", pipe_rdata); end
        nxt();
    endtask

    task automatic test_rw_both();
        set_pipe(1, 1, 8'h40, 32'hA5A5A5A5);
        set_dma(0, 0, 8'h00, 32'h0);
        mid();
        checks++; if (mem_wren !== 1'b1 || mem_rden !== 1'b0) begin
            errors++; $display("FAIL rw_both wren=%0b rden=%0b exp 1/0", mem_wren, mem_rden); end
        nxt();
        set_pipe(0, 0, 8'h00, 32'h0);
    endtask

    task automatic test_reset_mid_hold();
        set_pipe(0, 1, 8'h21, 32'h22222222);
        set_dma(1, 0, 8'h44, 32'h0);
        for (int c = 0; c < S; c++) begin mid(); nxt(); end
        mid();
        checks++; if (dma_gnt !== 1'b1 || pipe_hold !== 1'b1) begin
            errors++; $display("FAIL rmh_force gnt=%0b hold=%0b exp 1/1", dma_gnt, pipe_hold); end
        rst = 1'b0;
        #1;
        model_reset();
        model_eval();
        checks++; if (dma_rvalid !== 1'b0 || dut.wait_cnt !== '0) begin
            errors++; $display("FAIL rmh_reset rvalid=%0b cnt=%0d exp 0/0", dma_rvalid, dut.wait_cnt); end
        checks++; if (dma_gnt !== 1'b0 || pipe_hold !== 1'b0) begin
            errors++; $display("FAIL rmh_comb gnt=%0b hold=%0b exp 0/0", dma_gnt, pipe_hold); end
        nxt();
        rst = 1'b1;
        for (int c = 1; c <= S; c++) begin
            mid();
            checks++; if (dma_gnt !== 1'b0 || dma_rvalid !== 1'b0) begin
                errors++; $display("FAIL rmh_deny c=%0d gnt=%0b rvalid=%0b exp 0/0", c, dma_gnt, dma_rvalid); end
            nxt();
        end
        mid();
        checks++; if (dma_gnt !== 1'b1 || pipe_hold !== 1'b1) begin
            errors++; $display("FAIL rmh_reforce gnt=%0b hold=%0b exp 1/1", dma_gnt, pipe_hold); end
        nxt();
        set_dma(0, 0, 8'h00, 32'h0);
        mid();
        checks++; if (dma_rvalid !== 1'b1 || dma_rdata !== m_rdata) begin
            errors++; $display("FAIL rmh_rdata rvalid=%0b got=%h exp=%h", dma_rvalid, dma_rdata, m_rdata); end
        nxt();
        set_pipe(0, 0, 8'h00, 32'h0);
    endtask

    task automatic test_idle_gaps();
        for (int k = 0; k < 8; k++) begin
            set_pipe(1'($urandom_range(0, 1)), 1'b1, 8'($urandom_range(0, 31)), $urandom);
            if (k[0]) pipe_wren = ~pipe_rden;
            set_dma(1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 31)), $urandom);
            mid();
            checks++; if (dma_gnt !== 1'b0 || pipe_hold !== 1'b0) begin
                errors++; $display("FAIL gap_busy k=%0d gnt=%0b hold=%0b exp 0/0", k, dma_gnt, pipe_hold); end
            nxt();
            set_pipe(0, 0, 8'h00, 32'h0);
            mid();
            checks++; if (dma_gnt !== 1'b1 || pipe_hold !== 1'b0 || mem_address !== exp_addr) begin
                errors++; $display("FAIL gap_idle k=%0d gnt=%0b hold=%0b addr=%h exp 1/0/%h", k, dma_gnt, pipe_hold, mem_address, exp_addr); end
            nxt();
            set_dma(0, 0, 8'h00, 32'h0);
            mid();
            checks++; if (dma_rvalid !== m_rvalid || dma_rdata !== m_rdata) begin
                errors++; $display("FAIL gap_rdata k=%0d rvalid=%0b data=%h exp %0b/%h", k, dma_rvalid, dma_rdata, m_rvalid, m_rdata); end
            nxt();
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            if (!last_hold) begin
                case ($urandom_range(0, 3))
                    0: set_pipe(0, 0, 8'($urandom_range(0, 15)), $urandom);
                    1: set_pipe(1, 0, 8'($urandom_range(0, 15)), $urandom);
                    2: set_pipe(0, 1, 8'($urandom_range(0, 15)), $urandom);
                    default: set_pipe(1, 1, 8'($urandom_range(0, 15)), $urandom);
                endcase
            end
            if (!(dma_req && !last_gnt)) begin
                set_dma(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), $urandom);
            end
            mid();
            checks++; if (dma_gnt !== exp_gnt || pipe_hold !== exp_hold) begin
                errors++; $display("FAIL rnd_own n=%0d gnt=%0b hold=%0b exp %0b/%0b", n, dma_gnt, pipe_hold, exp_gnt, exp_hold); end
            checks++; if (mem_address !== exp_addr || mem_wren !== exp_wren || mem_rden !== exp_rden) begin
                errors++; $display("FAIL rnd_mux n=%0d addr=%h wr=%0b rd=%0b exp %h/%0b/%0b", n, mem_address, mem_wren, mem_rden, exp_addr, exp_wren, exp_rden); end
            if (exp_wren) begin
                checks++; if (mem_data !== exp_data) begin errors++; $display("FAIL rnd_wdata n=%0d got=%h exp=%h", n, mem_data, exp_data); end
            end
            if (exp_rden) begin
                checks++; if (pipe_rdata !== exp_q) begin errors++; $display("FAIL rnd_q n=%0d got=%h exp=%h", n, pipe_rdata, exp_q); end
            end
            checks++; if (dma_rvalid !== m_rvalid || dma_rdata !== m_rdata) begin
                errors++; $display("FAIL rnd_rdata n=%0d rvalid=%0b data=%h exp %0b/%h", n, dma_rvalid, dma_rdata, m_rvalid, m_rdata); end
            nxt();
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        model_reset();
        test_reset();
        test_starve();
        test_dma_write();
        test_rw_both();
        test_reset_mid_hold();
        test_idle_gaps();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
